bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Parametrised sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.
//  Adds ready/strobe handshake, held output register, optional signed input, digit count, overflow flag.
//  Sits between binary counters/accumulators and display or ASCII formatting logic.
// PARAMETERS
//  BIN_W   32  input width in bits (>=2)
//  DIGITS  10  BCD digits produced (>=1); fewer than ceil(BIN_W*log10(2)) is legal, O_OVF flags loss
//  SIGNED  0   1: I_DAT is two's complement, magnitude converted, sign on O_NEG; 0: unsigned
// PORTS
//  CLK     in   1                  clock, rising edge
//  RST_N   in   1                  asynchronous reset, active low
//  I_DAT   in   BIN_W              binary value, sampled when I_STB & I_RDY
//  I_STB   in   1                  request strobe (one cycle)
//  I_RDY   out  1                  converter idle, request accepted this cycle
//  O_DAT   out  4*DIGITS           BCD result, digit 0 in [3:0]; held until next completion
//  O_NEG   out  1                  result negative (SIGNED=1 only, else 0)
//  O_NDIG  out  $clog2(DIGITS+1)   significant digits, 1..DIGITS (value 0 -> 1)
//  O_OVF   out  1                  magnitude > 10^DIGITS-1; O_DAT = magnitude mod 10^DIGITS
//  O_STB   out  1                  one-cycle pulse, result registers updated
// BEHAVIOUR
//  Reset (RST_N low, async): state IDLE, I_RDY=1, O_DAT=0, O_NEG=0, O_NDIG=1, O_OVF=0, O_STB=0,
//   shift/BCD working regs and bit counter 0. Abort of in-flight conversion, no O_STB.
//  States: IDLE -> CONV -> DONE -> IDLE.
//  IDLE: I_RDY=1. I_STB=1 at edge k: load magnitude (SIGNED & I_DAT[MSB] -> -I_DAT, BIN_W-bit
//   unsigned; -2^(BIN_W-1) -> 2^(BIN_W-1)), latch sign, clear BCD regs, OVF sticky, counter=BIN_W; -> CONV.
//  CONV: I_RDY=0. Each edge: every digit >=5 gets +3, then {bcd,mag} shift left 1;
//   bit leaving top digit sets sticky OVF; counter-1. After BIN_W iterations (edge k+BIN_W) -> DONE.
//  DONE: edge k+BIN_W+1: O_DAT, O_NEG (sign & magnitude!=0), O_NDIG, O_OVF load;
//   O_STB=1 for the following cycle only; -> IDLE; I_RDY=1 in that same cycle.
//  Latency: O_STB high in cycle k+BIN_W+2 counting accept edge as k; throughput 1 per BIN_W+2 clocks.
//  Back-to-back: I_STB in the O_STB cycle is accepted (I_RDY=1); O_DAT holds until its own completion.
//  I_STB while I_RDY=0: ignored, no queueing, in-flight conversion unaffected.
//  O_NDIG = 1 + index of highest nonzero digit of final O_DAT; computed from final BCD regs.
//  Outputs never show partial results; change only at DONE edge or reset.
// TESTING
//  BIN_W=32,DIGITS=10,SIGNED=0: I_DAT=32'hFFFFFFFF -> O_DAT=40'h4294967295, O_NDIG=10, O_OVF=0, O_STB 34 clk after accept.
//  I_DAT=0 -> O_DAT=0, O_NDIG=1, O_NEG=0; then I_DAT=1000 in O_STB cycle -> accepted, O_DAT=...1000, O_NDIG=4.
//  SIGNED=1: I_DAT=32'h80000000 -> O_DAT=40'h2147483648, O_NEG=1; I_DAT=-1 -> O_DAT=1, O_NEG=1.
//  BIN_W=16,DIGITS=3: I_DAT=1234 -> O_DAT=12'h234, O_OVF=1, O_NDIG=3; I_DAT=999 -> O_OVF=0.
//  I_STB pulses at accept+5 with different I_DAT -> ignored, result matches first value, one O_STB only.
//  RST_N low at accept+10 -> all outputs reset values, no O_STB; next request converts correctly.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with strobe handshake, held result registers, optional signed input and overflow flag.
//
//  state | meaning
//  IDLE  | ready for a request, result registers hold the last conversion
//  CONV  | one add-3/shift iteration per clock, BIN_W iterations
//  DONE  | publish working registers to outputs, pulse O_STB
module bin_to_bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10,
    parameter int SIGNED = 0
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [BIN_W-1:0]             I_DAT,
    input  logic                         I_STB,
    output logic                         I_RDY,
    output logic [4*DIGITS-1:0]          O_DAT,
    output logic                         O_NEG,
    output logic [$clog2(DIGITS+1)-1:0]  O_NDIG,
    output logic                         O_OVF,
    output logic                         O_STB
);

    localparam int NW = $clog2(DIGITS + 1);
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    mag_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [4*DIGITS-1:0] bcd_shift;
    logic [CW-1:0]       cnt_q;
    logic                sign_q;
    logic                ovf_q;
    logic                load;
    logic                step;
    logic                finish;
    logic                neg_in;
    logic [BIN_W-1:0]    mag_in;
    logic [NW-1:0]       ndig;

    // Most negative input negates to itself, which read as unsigned is the correct magnitude.
    assign neg_in = (SIGNED != 0) && I_DAT[BIN_W-1];
    assign mag_in = neg_in ? (~I_DAT) + BIN_W'(1) : I_DAT;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shift = {bcd_adj[4*DIGITS-2:0], mag_q[BIN_W-1]};

    always_comb begin
        ndig = NW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                ndig = NW'(i + 1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        I_RDY   = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                I_RDY = 1'b1;
                if (I_STB) begin
                    load    = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mag_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            sign_q <= 1'b0;
            ovf_q  <= 1'b0;
            O_DAT  <= '0;
            O_NEG  <= 1'b0;
            O_NDIG <= NW'(1);
            O_OVF  <= 1'b0;
            O_STB  <= 1'b0;
        end else begin
            O_STB <= 1'b0;
            if (load) begin
                mag_q  <= mag_in;
                bcd_q  <= '0;
                cnt_q  <= CW'(BIN_W);
                sign_q <= neg_in;
                ovf_q  <= 1'b0;
            end else if (step) begin
                // A bit carried out of the top digit is worth 10^DIGITS: the value no longer fits.
                bcd_q <= bcd_shift;
                mag_q <= {mag_q[BIN_W-2:0], 1'b0};
                ovf_q <= ovf_q | bcd_adj[4*DIGITS-1];
                cnt_q <= cnt_q - CW'(1);
            end else if (finish) begin
                O_DAT  <= bcd_q;
                O_NEG  <= sign_q;
                O_NDIG <= ndig;
                O_OVF  <= ovf_q;
                O_STB  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: three configurations (unsigned 32/10, signed 32/10, 16/3)
// compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] dat_ab = '0;
    logic        stb_ab = 1'b0;
    logic        rdy_a, neg_a, ovf_a, stb_a;
    logic [39:0] o_dat_a;
    logic [3:0]  ndig_a;
    logic        rdy_b, neg_b, ovf_b, stb_b;
    logic [39:0] o_dat_b;
    logic [3:0]  ndig_b;
    logic [15:0] dat_c = '0;
    logic        stb_c = 1'b0;
    logic        rdy_c, neg_c, ovf_c, ostb_c;
    logic [11:0] o_dat_c;
    logic [1:0]  ndig_c;

    bin_to_bcd_seq #(.BIN_W(32), .DIGITS(10), .SIGNED(0)) u_a (
        .CLK(clk), .RST_N(rst_n), .I_DAT(dat_ab), .I_STB(stb_ab), .I_RDY(rdy_a),
        .O_DAT(o_dat_a), .O_NEG(neg_a), .O_NDIG(ndig_a), .O_OVF(ovf_a), .O_STB(stb_a));
    bin_to_bcd_seq #(.BIN_W(32), .DIGITS(10), .SIGNED(1)) u_b (
        .CLK(clk), .RST_N(rst_n), .I_DAT(dat_ab), .I_STB(stb_ab), .I_RDY(rdy_b),
        .O_DAT(o_dat_b), .O_NEG(neg_b), .O_NDIG(ndig_b), .O_OVF(ovf_b), .O_STB(stb_b));
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(3), .SIGNED(0)) u_c (
        .CLK(clk), .RST_N(rst_n), .I_DAT(dat_c), .I_STB(stb_c), .I_RDY(rdy_c),
        .O_DAT(o_dat_c), .O_NEG(neg_c), .O_NDIG(ndig_c), .O_OVF(ovf_c), .O_STB(ostb_c));

    typedef struct {
        logic [63:0] dat;
        logic        neg;
        int          ndig;
        logic        ovf;
        int          k;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal digits by repeated division; overflow when the magnitude exceeds 10^digits-1.
    function automatic exp_t model(input longint unsigned mag, input int digits, input logic neg,
                                   input int k);
        exp_t e;
        longint unsigned lim = 1;
        longint unsigned m;
        longint unsigned d;
        repeat (digits) lim = lim * 10;
        e.ovf  = (mag >= lim);
        e.neg  = neg && (mag != 0);
        e.k    = k;
        e.dat  = '0;
        e.ndig = 1;
        m = mag % lim;
        for (int i = 0; i < digits; i++) begin
            d = m % 10;
            e.dat = e.dat | (64'(d) << (4 * i));
            if (d != 0) e.ndig = i + 1;
            m = m / 10;
        end
        return e;
    endfunction

    task automatic chk_res(input string tag, input exp_t e, input longint unsigned dat,
                           input logic neg, input int ndig, input logic ovf, input int bw);
        chk({tag, "_dat"}, dat, e.dat);
        chk({tag, "_neg"}, 64'(neg), 64'(e.neg));
        chk({tag, "_ndig"}, 64'(ndig), 64'(e.ndig));
        chk({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
        chk({tag, "_latency"}, 64'(cyc + 1 - e.k), 64'(bw + 2));
    endtask

    logic [39:0] last_a;
    logic [11:0] last_c;
    exp_t        em;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_a = '0;
            last_c = '0;
        end else begin
            if (stb_a) begin
                if (qa.size() == 0) chk("a_extra_stb", 1, 0);
                else begin
                    em = qa.pop_front();
                    chk_res("a", em, 64'(o_dat_a), neg_a, int'(ndig_a), ovf_a, 32);
                end
                last_a = o_dat_a;
            end else begin
                chk("a_hold", 64'(o_dat_a), 64'(last_a));
            end
            if (stb_b) begin
                if (qb.size() == 0) chk("b_extra_stb", 1, 0);
                else begin
                    em = qb.pop_front();
                    chk_res("b", em, 64'(o_dat_b), neg_b, int'(ndig_b), ovf_b, 32);
                end
            end
            if (ostb_c) begin
                if (qc.size() == 0) chk("c_extra_stb", 1, 0);
                else begin
                    em = qc.pop_front();
                    chk_res("c", em, 64'(o_dat_c), neg_c, int'(ndig_c), ovf_c, 16);
                end
                last_c = o_dat_c;
            end else begin
                chk("c_hold", 64'(o_dat_c), 64'(last_c));
            end
        end
    end

    task automatic send_ab(input logic [31:0] d, output int k);
        int n = 0;
        longint unsigned mag;
        @(negedge clk);
        while (!rdy_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_a) begin
            chk("ab_rdy_timeout", 0, 1);
            k = -1;
            return;
        end
        dat_ab = d;
        stb_ab = 1'b1;
        k = cyc + 1;
        mag = d[31] ? (64'h1_0000_0000 - 64'(d)) : 64'(d);
        qa.push_back(model(64'(d), 10, 1'b0, k));
        qb.push_back(model(mag, 10, d[31], k));
        @(negedge clk);
        stb_ab = 1'b0;
    endtask

    task automatic send_c(input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (!rdy_c && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_c) begin
            chk("c_rdy_timeout", 0, 1);
            return;
        end
        dat_c = d;
        stb_c = 1'b1;
        qc.push_back(model(64'(d), 3, 1'b0, cyc + 1));
        @(negedge clk);
        stb_c = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, k1, n;
        logic [31:0] r;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dat", 64'(o_dat_a), 0);
        chk("rst_ndig", 64'(ndig_a), 1);
        chk("rst_rdy", 64'(rdy_a), 1);
        chk("rst_c_ndig", 64'(ndig_c), 1);
        #2 rst_n = 1'b1;

        send_ab(32'hFFFF_FFFF, k0);
        send_ab(32'd0, k0);
        send_ab(32'd1000, k1);
        chk("b2b_accept_gap", 64'(k1 - k0), 34);
        send_ab(32'h8000_0000, k0);

        // Request during conversion must be dropped without disturbing the result.
        send_ab(32'd987654321, k0);
        repeat (4) @(negedge clk);
        dat_ab = 32'd5;
        stb_ab = 1'b1;
        chk("ignore_rdy", 64'(rdy_a), 0);
        @(negedge clk);
        stb_ab = 1'b0;

        // Reset mid-conversion: abort, no result, then a clean conversion.
        send_ab(32'd12345678, k0);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        chk("abort_dat", 64'(o_dat_a), 0);
        chk("abort_ndig", 64'(ndig_a), 1);
        chk("abort_neg_b", 64'(neg_b), 0);
        chk("abort_stb", 64'(stb_a), 0);
        chk("abort_rdy", 64'(rdy_a), 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        send_ab(32'd42, k0);

        for (int i = 0; i < 25; i++) begin
            r = $urandom();
            if ($urandom_range(0, 3) == 0) r = $urandom_range(0, 999);
            send_ab(r, k0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        send_c(16'd1234);
        send_c(16'd999);
        send_c(16'hFFFF);
        send_c(16'd1000);
        send_c(16'd0);
        for (int i = 0; i < 15; i++) begin
            send_c(16'($urandom()));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_pending", 64'(qa.size() + qb.size() + qc.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
